// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout and serialiser state encoding.
package uart_pkg;

   localparam logic [3:0] TXDATA_OFS = 4'h0;
   localparam logic [3:0] STATUS_OFS = 4'h4;

   localparam int unsigned ST_FULL    = 0;
   localparam int unsigned ST_EMPTY   = 1;
   localparam int unsigned ST_BUSY    = 2;
   localparam int unsigned ST_OVF     = 3;
   localparam int unsigned ST_CNT_LSB = 4;
   localparam int unsigned ST_CNT_W   = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } txState_e;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with show-ahead head output. The caller guarantees
// push only when not full and pop only when not empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         headC,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic [CW-1:0]    countNext;

   assign headC = mem[rdPtr];

   always_comb begin
      countNext = count;
      if (push && !pop)
         countNext = count + CW'(1);
      else if (pop && !push)
         countNext = count - CW'(1);
   end

   // Storage carries no reset; pointer reset is what discards contents.
   always_ff @(posedge clk) begin
      if (push)
         mem[wrPtr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (push)
            wrPtr <= wrPtr + AW'(1);
         if (pop)
            rdPtr <= rdPtr + AW'(1);
         count <= countNext;
         full  <= (countNext == CW'(DEPTH));
         empty <= (countNext == '0);
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register decode,
// sticky overflow flag, byte FIFO and bit serialiser.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic [3:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        irq
);

   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BAUD_W = $clog2(CLK_DIV);

   txState_e          state;
   logic [BAUD_W-1:0] baudCnt;
   logic [2:0]        bitIdx;
   logic [7:0]        shiftReg;
   logic              ovf;

   logic              wrTx;
   logic              wrStatus;
   logic              fifoPush;
   logic              pop;
   logic              baudLast;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [7:0]        fifoHead;
   logic [CNT_W-1:0]  fifoCount;
   logic [31:0]       statusWord;
   logic              unusedBits;

   assign unusedBits = &{1'b0, wdata[31:8], addr[1:0]};

   // Decode, push gating and pop request.
   always_comb begin
      wrTx       = sel && we && (addr[3:2] == TXDATA_OFS[3:2]);
      wrStatus   = sel && we && (addr[3:2] == STATUS_OFS[3:2]);
      fifoPush   = wrTx && !fifoFull;
      baudLast   = (baudCnt == BAUD_W'(CLK_DIV - 1));
      pop        = !fifoEmpty && ((state == IDLE) || ((state == STOP) && baudLast));
      statusWord = '0;
      statusWord[ST_FULL]  = fifoFull;
      statusWord[ST_EMPTY] = fifoEmpty;
      statusWord[ST_BUSY]  = (state != IDLE);
      statusWord[ST_OVF]   = ovf;
      statusWord[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifoCount);
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifoPush),
      .pop   (pop),
      .wdata (wdata[7:0]),
      .headC (fifoHead),
      .full  (fifoFull),
      .empty (fifoEmpty),
      .count (fifoCount)
   );

   // Registered read port and sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
         ovf   <= 1'b0;
      end else begin
         if (sel && (addr[3:2] == STATUS_OFS[3:2]))
            rdata <= statusWord;
         else
            rdata <= '0;
         if (wrTx && fifoFull)
            ovf <= 1'b1;
         else if (wrStatus && wdata[ST_OVF])
            ovf <= 1'b0;
      end
   end

   // Serialiser: tx follows the state one cycle later, so each bit spans CLK_DIV cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baudCnt  <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         tx       <= 1'b1;
         irq      <= 1'b1;
      end else begin
         irq <= fifoEmpty && (state == IDLE);
         if (state == IDLE || baudLast)
            baudCnt <= '0;
         else
            baudCnt <= baudCnt + BAUD_W'(1);
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shiftReg <= fifoHead;
                  bitIdx   <= '0;
                  state    <= START;
               end
            end
            START: begin
               tx <= 1'b0;
               if (baudLast)
                  state <= DATA;
            end
            DATA: begin
               tx <= shiftReg[0];
               if (baudLast) begin
                  shiftReg <= {1'b0, shiftReg[7:1]};
                  bitIdx   <= bitIdx + 3'(1);
                  if (bitIdx == 3'd7)
                     state <= STOP;
               end
            end
            STOP: begin
               tx <= 1'b1;
               if (baudLast) begin
                  if (pop) begin
                     shiftReg <= fifoHead;
                     bitIdx   <= '0;
                     state    <= START;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLK_DIV=4, FIFO_DEPTH=4; expected
// frames and STATUS words are hand-derived constants.
module tb_mmio_uart_tx;

   localparam int unsigned CLK_DIV    = 4;
   localparam int unsigned FIFO_DEPTH = 4;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        sel   = 1'b0;
   logic        we    = 1'b0;
   logic [3:0]  addr  = 4'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        tx;
   logic        irq;

   int nVec = 0;
   int nBad = 0;

   mmio_uart_tx #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .sel   (sel),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .tx    (tx),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeReg(input logic [3:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      tick();
      sel = 1'b0; we = 1'b0; addr = 4'h0; wdata = 32'h0;
   endtask

   task automatic readReg(input logic [3:0] a, output logic [31:0] d);
      sel = 1'b1; we = 1'b0; addr = a;
      tick();
      sel = 1'b0; addr = 4'h0;
      d = rdata;
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Checks 40 cycles of one frame, starting one cycle before the start bit.
   task automatic expectFrame(input logic [7:0] b, input string tag);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 40; i++) begin
         tick();
         checkVal($sformatf("%s_c%0d", tag, i), 32'(tx), 32'(frame[i/4]));
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        sawLow;

      tick();
      tick();
      checkVal("rst_rdata", rdata, 32'h0);
      checkVal("rst_tx", 32'(tx), 32'h1);
      checkVal("rst_irq", 32'(irq), 32'h1);
      rst = 1'b0;
      tick();

      readReg(4'h4, rd);
      checkVal("rd_status_idle", rd, 32'h2);
      tick();
      checkVal("rd_desel_zero", rdata, 32'h0);
      readReg(4'h0, rd);
      checkVal("rd_txdata_zero", rd, 32'h0);
      readReg(4'h8, rd);
      checkVal("rd_off8_zero", rd, 32'h0);
      writeReg(4'hC, 32'hFF);
      readReg(4'h4, rd);
      checkVal("wr_offc_ignored", rd, 32'h2);

      // Single byte 0xA5
      writeReg(4'h0, 32'hA5);
      checkVal("a5_tx_n0", 32'(tx), 32'h1);
      tick();
      checkVal("a5_tx_n1", 32'(tx), 32'h1);
      checkVal("a5_irq_busy", 32'(irq), 32'h0);
      expectFrame(8'hA5, "a5");
      checkVal("a5_irq_n41", 32'(irq), 32'h0);
      tick();
      checkVal("a5_tx_idle", 32'(tx), 32'h1);
      checkVal("a5_irq_done", 32'(irq), 32'h1);

      // Back-to-back 0x00, 0xFF
      writeReg(4'h0, 32'h00);
      writeReg(4'h0, 32'hFF);
      expectFrame(8'h00, "b2b0");
      expectFrame(8'hFF, "b2b1");
      tick();
      checkVal("b2b_tx_idle", 32'(tx), 32'h1);
      checkVal("b2b_irq_done", 32'(irq), 32'h1);

      // Overflow: six consecutive pushes
      for (int i = 0; i < 6; i++)
         writeReg(4'h0, 32'h11 + 32'(i));
      readReg(4'h4, rd);
      checkVal("ovf_status", rd, 32'h4D);
      writeReg(4'h4, 32'h8);
      readReg(4'h4, rd);
      checkVal("ovf_cleared", rd, 32'h45);
      doReset();
      readReg(4'h4, rd);
      checkVal("ovf_after_rst", rd, 32'h2);

      // Full FIFO push racing the STOP-end pop
      for (int i = 0; i < 5; i++)
         writeReg(4'h0, 32'h21 + 32'(i));
      readReg(4'h4, rd);
      checkVal("race_full", rd, 32'h45);
      repeat (35) tick();
      writeReg(4'h0, 32'h77);
      readReg(4'h4, rd);
      checkVal("race_drop", rd, 32'h3C);

      // Reset in the middle of DATA bit 3
      doReset();
      writeReg(4'h0, 32'hA5);
      writeReg(4'h0, 32'h3C);
      writeReg(4'h0, 32'hC3);
      repeat (17) tick();
      checkVal("mid_pre_tx", 32'(tx), 32'h0);
      rst = 1'b1;
      #1;
      checkVal("mid_async_tx", 32'(tx), 32'h1);
      tick();
      tick();
      rst = 1'b0;
      tick();
      readReg(4'h4, rd);
      checkVal("mid_status", rd, 32'h2);
      sawLow = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (tx !== 1'b1)
            sawLow = 1'b1;
      end
      checkVal("mid_no_residual", 32'(sawLow), 32'h0);
      checkVal("mid_irq", 32'(irq), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
